// File: rtl/rat_pkg.sv
// Shared types for the RAT CPU control path: flow-op codes, sequencer states
// and the default interrupt vector.
package rat_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_BRC  = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4,
    BR_RETI = 3'd5,
    BR_SEI  = 3'd6,
    BR_CLI  = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    RST_S   = 2'd0,
    FETCH_S = 2'd1,
    EXEC_S  = 2'd2,
    INTR_S  = 2'd3
  } seq_state_e;

  localparam logic [9:0] INTR_VEC_DEFAULT = 10'h3FF;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Pushes when full and pops when empty leave the pointer
// untouched; an empty stack reads back as zero.
module ret_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int PW = IW + 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     wr_idx, top_idx;

  assign full    = (ptr_q == PW'(STACK_DEPTH));
  assign empty   = (ptr_q == '0);
  assign wr_idx  = ptr_q[IW-1:0];
  assign top_idx = IW'(ptr_q - PW'(1));

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= data_in;
    end
  end

  assign data_out = empty ? '0 : mem_q[top_idx];

endmodule

// File: rtl/pc_sequencer.sv
// RAT CPU program-counter sequencer: FETCH/EXEC/INTR control, flow-op decode,
// return-address stack and interrupt flag. The PC register itself lives outside.
module pc_sequencer
  import rat_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC    = ADDR_W'(INTR_VEC_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC_COUNT,
  input  logic [2:0]        BR_TYPE,
  input  logic              BR_COND,
  input  logic [ADDR_W-1:0] BR_ADDR,
  input  logic              INTR,
  output logic              PC_LD,
  output logic              PC_INC,
  output logic [ADDR_W-1:0] PC_DIN,
  output logic              IS_FETCH,
  output logic              INTR_ACK,
  output logic              I_FLAG,
  output logic              STK_ERR
);

  seq_state_e        state_q, state_d;
  logic              i_flag_q, i_flag_d;
  logic              stk_err_q, stk_err_d;
  logic              stk_push, stk_pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;
  br_type_e          br;

  assign br = br_type_e'(BR_TYPE);

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (stk_push),
    .pop      (stk_pop),
    .data_in  (PC_COUNT),
    .data_out (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= RST_S;
      i_flag_q  <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_flag_q  <= i_flag_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_flag_d  = i_flag_q;
    stk_err_d = stk_err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    PC_LD     = 1'b0;
    PC_INC    = 1'b0;
    PC_DIN    = '0;
    IS_FETCH  = 1'b0;
    INTR_ACK  = 1'b0;

    unique case (state_q)
      RST_S: begin
        state_d = FETCH_S;
      end

      FETCH_S: begin
        IS_FETCH = 1'b1;
        PC_INC   = 1'b1;
        state_d  = EXEC_S;
      end

      EXEC_S: begin
        case (br)
          BR_JMP: begin
            PC_LD  = 1'b1;
            PC_DIN = BR_ADDR;
          end
          BR_BRC: begin
            PC_LD  = BR_COND;
            PC_DIN = BR_COND ? BR_ADDR : '0;
          end
          BR_CALL: begin
            stk_push = 1'b1;
            PC_LD    = 1'b1;
            PC_DIN   = BR_ADDR;
            if (stk_full) stk_err_d = 1'b1;
          end
          BR_RET, BR_RETI: begin
            stk_pop = 1'b1;
            PC_LD   = 1'b1;
            PC_DIN  = stk_top;
            if (stk_empty) stk_err_d = 1'b1;
            if (br == BR_RETI) i_flag_d = 1'b1;
          end
          BR_SEI:  i_flag_d = 1'b1;
          BR_CLI:  i_flag_d = 1'b0;
          default: ;
        endcase
        // The mask used here is the flag as it stood before this instruction.
        state_d = (INTR && i_flag_q) ? INTR_S : FETCH_S;
      end

      INTR_S: begin
        stk_push = 1'b1;
        PC_LD    = 1'b1;
        PC_DIN   = INTR_VEC;
        INTR_ACK = 1'b1;
        i_flag_d = 1'b0;
        if (stk_full) stk_err_d = 1'b1;
        state_d  = FETCH_S;
      end

      default: state_d = RST_S;
    endcase
  end

  assign I_FLAG  = i_flag_q;
  assign STK_ERR = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: emulates the program counter around the DUT and
// checks each instruction against a queue-based model of the RAT flow rules.
module tb_pc_sequencer;
  import rat_pkg::*;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] pc_env;
  logic [2:0] BR_TYPE = '0;
  logic       BR_COND = 1'b0;
  logic [9:0] BR_ADDR = '0;
  logic       INTR = 1'b0;
  logic       PC_LD, PC_INC, IS_FETCH, INTR_ACK, I_FLAG, STK_ERR;
  logic [9:0] PC_DIN;

  pc_sequencer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PC_COUNT (pc_env),
    .BR_TYPE  (BR_TYPE),
    .BR_COND  (BR_COND),
    .BR_ADDR  (BR_ADDR),
    .INTR     (INTR),
    .PC_LD    (PC_LD),
    .PC_INC   (PC_INC),
    .PC_DIN   (PC_DIN),
    .IS_FETCH (IS_FETCH),
    .INTR_ACK (INTR_ACK),
    .I_FLAG   (I_FLAG),
    .STK_ERR  (STK_ERR)
  );

  always #5 CLK = ~CLK;

  // Program counter that the sequencer steers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      pc_env <= '0;
    else if (PC_LD)  pc_env <= PC_DIN;
    else if (PC_INC) pc_env <= pc_env + 10'd1;
  end

  int errors = 0;
  int checks = 0;

  logic [9:0] m_stack[$];
  bit         m_iflag, m_err;
  logic [9:0] m_pc;

  logic       obs_ld;
  logic [9:0] obs_din;
  logic       obs_intr;

  typedef struct {
    logic [2:0] op;
    logic       cond;
    logic [9:0] addr;
    logic       intr;
    logic       ld;
    logic [9:0] din;
    logic       taken;
    logic       iflag;
    logic       err;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_push(input logic [9:0] v);
    if (m_stack.size() == DEPTH) m_err = 1'b1;
    else m_stack.push_back(v);
  endtask

  task automatic m_pop(output logic [9:0] v);
    if (m_stack.size() == 0) begin
      v = '0;
      m_err = 1'b1;
    end else begin
      v = m_stack.pop_back();
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    BR_TYPE = '0; BR_COND = 1'b0; BR_ADDR = '0; INTR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_is_fetch", IS_FETCH, 0);
    chk("rst_pc_inc",   PC_INC,   0);
    chk("rst_pc_ld",    PC_LD,    0);
    chk("rst_pc_din",   PC_DIN,   0);
    chk("rst_intr_ack", INTR_ACK, 0);
    chk("rst_i_flag",   I_FLAG,   0);
    chk("rst_stk_err",  STK_ERR,  0);
    RST_N = 1'b1;
    #1;
    chk("rsts_pc_inc",   PC_INC,   0);
    chk("rsts_is_fetch", IS_FETCH, 0);
    chk("rsts_pc_ld",    PC_LD,    0);
    m_stack.delete();
    m_iflag = 1'b0;
    m_err   = 1'b0;
    m_pc    = '0;
    @(negedge CLK);
  endtask

  task automatic do_fetch();
    BR_TYPE = '0; BR_COND = 1'b0; BR_ADDR = '0; INTR = 1'b0;
    #1;
    chk("fetch_is_fetch", IS_FETCH, 1);
    chk("fetch_pc_inc",   PC_INC,   1);
    chk("fetch_pc_ld",    PC_LD,    0);
    chk("fetch_ack",      INTR_ACK, 0);
    chk("fetch_pc",       pc_env,   m_pc);
    m_pc = m_pc + 10'd1;
    @(negedge CLK);
  endtask

  task automatic do_exec(input logic [2:0] op, input logic cond,
                         input logic [9:0] addr, input logic intr);
    logic       exp_ld;
    logic [9:0] exp_din;
    bit         take;
    BR_TYPE = op; BR_COND = cond; BR_ADDR = addr; INTR = intr;
    #1;
    exp_ld  = 1'b0;
    exp_din = '0;
    take    = intr && m_iflag;
    case (op)
      3'd1: begin exp_ld = 1'b1; exp_din = addr; end
      3'd2: if (cond) begin exp_ld = 1'b1; exp_din = addr; end
      3'd3: begin m_push(m_pc); exp_ld = 1'b1; exp_din = addr; end
      3'd4: begin m_pop(exp_din); exp_ld = 1'b1; end
      3'd5: begin m_pop(exp_din); exp_ld = 1'b1; m_iflag = 1'b1; end
      3'd6: m_iflag = 1'b1;
      3'd7: m_iflag = 1'b0;
      default: ;
    endcase
    chk("exec_pc_ld",    PC_LD,    exp_ld);
    chk("exec_pc_inc",   PC_INC,   0);
    chk("exec_is_fetch", IS_FETCH, 0);
    chk("exec_ack",      INTR_ACK, 0);
    if (exp_ld) chk("exec_pc_din", PC_DIN, exp_din);
    obs_ld  = PC_LD;
    obs_din = PC_DIN;
    if (exp_ld) m_pc = exp_din;
    @(negedge CLK);
    chk("exec_i_flag",  I_FLAG,  m_iflag);
    chk("exec_stk_err", STK_ERR, m_err);
    obs_intr = INTR_ACK;
    chk("intr_entry", INTR_ACK, take);
    if (take) begin
      BR_TYPE = '0; INTR = 1'b0;
      #1;
      chk("intr_pc_ld",    PC_LD,    1);
      chk("intr_pc_din",   PC_DIN,   10'h3FF);
      chk("intr_pc_inc",   PC_INC,   0);
      chk("intr_is_fetch", IS_FETCH, 0);
      m_push(m_pc);
      m_iflag = 1'b0;
      m_pc    = 10'h3FF;
      @(negedge CLK);
      chk("intr_i_flag",  I_FLAG,  m_iflag);
      chk("intr_stk_err", STK_ERR, m_err);
    end
  endtask

  initial begin
    //          op    c     addr     i     ld    din      tk    if    err
    tbl[0]  = '{3'd1, 1'b0, 10'h02A, 1'b0, 1'b1, 10'h02A, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd2, 1'b0, 10'h003, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 1'b1, 10'h010, 1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 1'b0, 10'h100, 1'b0, 1'b1, 10'h100, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd3, 1'b0, 10'h200, 1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd3, 1'b0, 10'h300, 1'b0, 1'b1, 10'h300, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 10'h201, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 10'h101, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3'd6, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3'd3, 1'b0, 10'h050, 1'b1, 1'b1, 10'h050, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3'd5, 1'b0, 10'h000, 1'b0, 1'b1, 10'h050, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 10'h014, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{3'd7, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      do_fetch();
      do_exec(tbl[i].op, tbl[i].cond, tbl[i].addr, tbl[i].intr);
      chk($sformatf("tbl%0d_ld", i), obs_ld, tbl[i].ld);
      if (tbl[i].ld) chk($sformatf("tbl%0d_din", i), obs_din, tbl[i].din);
      chk($sformatf("tbl%0d_intr", i), obs_intr, tbl[i].taken);
      chk($sformatf("tbl%0d_iflag", i), I_FLAG, tbl[i].iflag);
      chk($sformatf("tbl%0d_err", i), STK_ERR, tbl[i].err);
    end

    // Reset asserted in the middle of an EXEC with STK_ERR already set.
    do_fetch();
    BR_TYPE = 3'd1; BR_ADDR = 10'h2A;
    #1;
    chk("midrst_pre_ld", PC_LD, 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_pc_ld",   PC_LD,   0);
    chk("midrst_pc_din",  PC_DIN,  0);
    chk("midrst_stk_err", STK_ERR, 0);
    chk("midrst_i_flag",  I_FLAG,  0);
    do_reset();

    // Nine nested CALLs into an eight-entry stack; the ninth return is lost.
    for (int i = 0; i < 9; i++) begin
      do_fetch();
      do_exec(3'd3, 1'b0, 10'h100 + 10'(i * 16), 1'b0);
      chk($sformatf("ovf_err_%0d", i), STK_ERR, (i == 8) ? 1 : 0);
    end
    do_fetch();
    do_exec(3'd4, 1'b0, 10'h000, 1'b0);
    chk("ovf_first_ret", obs_din, 10'h161);
    for (int i = 0; i < 7; i++) begin
      do_fetch();
      do_exec(3'd4, 1'b0, 10'h000, 1'b0);
    end
    chk("ovf_last_ret", obs_din, 10'h001);

    // RET straight after reset pops an empty stack.
    do_reset();
    do_fetch();
    do_exec(3'd4, 1'b0, 10'h155, 1'b0);
    chk("empty_ret_din", obs_din, 0);
    chk("empty_ret_err", STK_ERR, 1);

    // Random instruction stream against the model.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        do_fetch();
        do_exec(3'($urandom_range(0, 7)), 1'($urandom), 10'($urandom),
                ($urandom_range(0, 3) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
